// File: rtl/osd_stm_event_packetizer.sv
// -----------------------------------------------------------------------------
// osd_stm_event_packetizer
//
// Takes qualified software-trace events and timestamps them. The events are
// buffered in a small FIFO, and each one is sent out as a DII event packet
// under ready/valid backpressure. When an event cannot be buffered it is
// dropped and counted. The drop count is reported later in a dedicated
// overflow packet.
//
// While a drop lockout is pending, no further event is accepted. This keeps
// every buffered event ahead of every dropped one in the output stream.
//
// Parameters
//   VALWIDTH    trace value width (multiple of 16)
//   FIFO_DEPTH  event FIFO entries (power of two, >= 2)
//   TS_INIT     timestamp value loaded at reset (0 in normal use)
//
// Ports
//   clk               clock, everything on the rising edge
//   rst               synchronous active-low reset
//   id                own DII address (SRC word)
//   event_dest        destination DII address (DEST word)
//   enable            capture enable; strobes are ignored while low
//   trace_valid       single-cycle event strobe
//   trace_id          event id
//   trace_value       event value
//   debug_out_valid   flit valid (high in every non-idle state)
//   debug_out_last    final flit of a packet
//   debug_out_data    flit payload
//   debug_out_ready   sink ready; a flit moves on valid && ready
//   overflow          high while the drop lockout is active
// -----------------------------------------------------------------------------
module osd_stm_event_packetizer #(
  parameter int          VALWIDTH   = 32,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] TS_INIT    = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         id,
  input  logic [15:0]         event_dest,
  input  logic                enable,
  input  logic                trace_valid,
  input  logic [15:0]         trace_id,
  input  logic [VALWIDTH-1:0] trace_value,
  output logic                debug_out_valid,
  output logic                debug_out_last,
  output logic [15:0]         debug_out_data,
  input  logic                debug_out_ready,
  output logic                overflow
);

  localparam int NWORDS = VALWIDTH / 16;
  localparam int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int EW     = 32 + 16 + VALWIDTH;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
  localparam logic [AW:0]     PTR_ONE  = {{AW{1'b0}}, 1'b1};

  localparam logic [15:0] HDR_EVENT = 16'h8000;  // TYPE=2'b10, TYPE_SUB=4'h0
  localparam logic [15:0] HDR_OVF   = 16'h9400;  // TYPE=2'b10, TYPE_SUB=4'h5

  typedef enum logic [3:0] {
    S_IDLE, S_DEST, S_SRC, S_HDR, S_TS_LO, S_TS_HI, S_EVID, S_VAL, S_OVF_CNT
  } state_t;

  state_t          state_q, state_d;
  logic            is_ovf_q, is_ovf_d;   // current packet is an overflow packet
  logic [IDXW-1:0] idx_q, idx_d;         // VALUE word index
  logic [31:0]     ts_q;
  logic [AW:0]     wr_ptr_q, rd_ptr_q;   // extra MSB separates full from empty
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic            lockout_q, lockout_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic [15:0]     cnt_q;                // drop count frozen for the overflow packet

  logic                fifo_empty, fifo_full;
  logic                strobe, accept, drop, hs, sel_ovf, pop;
  logic [15:0]         drop_base;
  logic [EW-1:0]       head;
  logic [31:0]         head_ts;
  logic [15:0]         head_id;
  logic [VALWIDTH-1:0] head_val;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Full is taken from registered pointers, so a same-cycle pop never
  // rescues an event that arrives while the FIFO is full.
  assign strobe = enable && trace_valid;
  assign accept = strobe && !fifo_full && !lockout_q;
  assign drop   = strobe && (fifo_full || lockout_q);

  assign hs       = debug_out_valid && debug_out_ready;
  assign overflow = lockout_q;

  assign head     = mem[rd_ptr_q[AW-1:0]];
  assign head_ts  = head[EW-1 -: 32];
  assign head_id  = head[VALWIDTH +: 16];
  assign head_val = head[VALWIDTH-1:0];

  // Packet FSM: next state and flit outputs.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d         = state_q;
    is_ovf_d        = is_ovf_q;
    idx_d           = idx_q;
    sel_ovf         = 1'b0;
    pop             = 1'b0;
    debug_out_valid = (state_q != S_IDLE);
    debug_out_last  = 1'b0;
    debug_out_data  = 16'h0000;

    case (state_q)
      S_IDLE: begin
        // A pending overflow can only be reported once the FIFO has drained.
        if (!fifo_empty) begin
          state_d  = S_DEST;
          is_ovf_d = 1'b0;
        end else if (lockout_q) begin
          state_d  = S_DEST;
          is_ovf_d = 1'b1;
          sel_ovf  = 1'b1;
        end
      end
      S_DEST: begin
        debug_out_data = event_dest;
        if (hs) state_d = S_SRC;
      end
      S_SRC: begin
        debug_out_data = id;
        if (hs) state_d = S_HDR;
      end
      S_HDR: begin
        debug_out_data = is_ovf_q ? HDR_OVF : HDR_EVENT;
        if (hs) state_d = is_ovf_q ? S_OVF_CNT : S_TS_LO;
      end
      S_TS_LO: begin
        debug_out_data = head_ts[15:0];
        if (hs) state_d = S_TS_HI;
      end
      S_TS_HI: begin
        debug_out_data = head_ts[31:16];
        if (hs) state_d = S_EVID;
      end
      S_EVID: begin
        debug_out_data = head_id;
        if (hs) begin
          state_d = S_VAL;
          idx_d   = '0;
        end
      end
      S_VAL: begin
        debug_out_data = head_val[{idx_q, 4'b0000} +: 16];
        debug_out_last = (idx_q == LAST_IDX);
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            pop     = 1'b1;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      S_OVF_CNT: begin
        debug_out_data = cnt_q;
        debug_out_last = 1'b1;
        if (hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Drop counter and lockout. Selecting an overflow packet empties the
  // counter first, so a drop on that same edge counts into the fresh value
  // and sets lockout again.
  always_comb begin
    drop_base  = sel_ovf ? 16'h0000 : drop_cnt_q;
    drop_cnt_d = drop_base;
    if (drop && (drop_base != 16'hFFFF)) drop_cnt_d = drop_base + 16'd1;
    lockout_d = (lockout_q && !sel_ovf) || drop;
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples values from before the edge.
    if (!rst) begin
      state_q    <= S_IDLE;
      is_ovf_q   <= 1'b0;
      idx_q      <= '0;
      ts_q       <= TS_INIT;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lockout_q  <= 1'b0;
      drop_cnt_q <= 16'h0000;
      cnt_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      is_ovf_q   <= is_ovf_d;
      idx_q      <= idx_d;
      ts_q       <= ts_q + 32'd1;
      lockout_q  <= lockout_d;
      drop_cnt_q <= drop_cnt_d;
      if (accept)  wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (sel_ovf) cnt_q    <= drop_cnt_q;
    end
  end

  // Event storage.
  // NOTE: the storage array has no reset. Entries are only ever read
  // between a write and the matching pop, so a reset of the pointers alone
  // is enough.
  always_ff @(posedge clk) begin
    if (rst && accept) mem[wr_ptr_q[AW-1:0]] <= {ts_q, trace_id, trace_value};
  end

endmodule
